// File: rtl/packet_framer.sv
// -----------------------------------------------------------------------------
// packet_framer
//
// Snapshots the correlator payload on a trigger and serializes it as a framed
// byte stream for the UART transmitter:
//   header  : 64-bit timestamp, MSB first
//   payload : PAYLOAD_SIZE bits of the captured `pulses`, MSB first
//   footer  : {sequence[31:0], 24'd0, checksum[7:0]}, MSB first
// Each field is sent as ASCII hex characters (one per nibble, uppercase) or,
// with BINARY=1, as raw bytes. The checksum is the 8-bit modular sum of every
// byte transferred during the header and payload, exactly as transmitted.
//
// Optional feature (compile-time macro PACKET_TERMINATOR_EN):
//   defined   -> after the footer a TERM state sends one 0x0D byte, which is
//                not part of the checksum.
//   undefined -> the frame ends with the last footer byte.
//
// Parameters:
//   PAYLOAD_SIZE  payload width in bits (multiple of 8)
//   BINARY        0 = ASCII hex nibbles, 1 = raw bytes
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low reset
//   enable    in   permits new captures; never aborts a frame in flight
//   trigger   in   capture request, sampled every cycle
//   pulses    in   correlator payload (PAYLOAD_SIZE bits)
//   tx_data   out  byte to the transmitter
//   tx_valid  out  tx_data is valid
//   tx_ready  in   transmitter accepts the byte
//   busy      out  a frame is in progress (state != IDLE)
//   overrun   out  one-cycle pulse: a trigger arrived while busy and was dropped
//
// Handshake: a byte transfers on a rising clk edge where tx_valid & tx_ready.
// Once tx_valid is high, tx_valid and tx_data hold stable until that transfer;
// the next byte is presented in the very next cycle, so with tx_ready held
// high the stream runs at one byte per clock.
//
// The FSM state is held in the enum signal `state` for observation.
// -----------------------------------------------------------------------------
module packet_framer #(
    parameter int PAYLOAD_SIZE = 96,
    parameter int BINARY       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    trigger,
    input  logic [PAYLOAD_SIZE-1:0] pulses,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    overrun
);

    // Unit = bits consumed per transmitted byte.
    localparam int UNIT      = (BINARY != 0) ? 8 : 4;
    localparam int HDR_UNITS = 64 / UNIT;
    localparam int PAY_UNITS = PAYLOAD_SIZE / UNIT;
    localparam int MAX_UNITS = (PAY_UNITS > HDR_UNITS) ? PAY_UNITS : HDR_UNITS;
    localparam int CNT_W     = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_UNITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        FOOTER
`ifdef PACKET_TERMINATOR_EN
        ,
        TERM
`endif
    } state_t;

    state_t                  state;
    logic [63:0]             ts;        // free-running timestamp
    logic [31:0]             seq;       // next sequence number to hand out
    logic [31:0]             seq_lat;   // sequence number of the frame in flight
    logic [63:0]             word_sr;   // header word, later reused for the footer
    logic [PAYLOAD_SIZE-1:0] pay_sr;    // shadow copy of the payload
    logic [CNT_W-1:0]        cnt;       // unit index within the current field
    logic [7:0]              sum;       // running checksum of transmitted bytes

    logic                    accept;
    logic [63:0]             word_next;
    logic [PAYLOAD_SIZE-1:0] pay_next;
    logic [7:0]              sum_next;
    logic [63:0]             footer_word;

    // Map one unit (right-aligned in the byte) to the transmitted byte.
    function automatic logic [7:0] encode(input logic [7:0] u);
        if (BINARY != 0) begin
            return u;
        end else if (u[3:0] < 4'd10) begin
            return 8'h30 + {4'h0, u[3:0]};
        end else begin
            // 0x37 + 10 = 'A'
            return 8'h37 + {4'h0, u[3:0]};
        end
    endfunction

    // Encoded byte for the most significant unit of a 64-bit word.
    function automatic logic [7:0] word_unit(input logic [63:0] v);
        if (BINARY != 0) begin
            return encode(v[63:56]);
        end else begin
            return encode({4'h0, v[63:60]});
        end
    endfunction

    // Encoded byte for the most significant unit of the payload.
    function automatic logic [7:0] pay_unit(input logic [PAYLOAD_SIZE-1:0] v);
        if (BINARY != 0) begin
            return encode(v[PAYLOAD_SIZE-1 -: 8]);
        end else begin
            return encode({4'h0, v[PAYLOAD_SIZE-1 -: 4]});
        end
    endfunction

    always_comb begin
        accept      = tx_valid & tx_ready;
        word_next   = word_sr << UNIT;
        pay_next    = pay_sr << UNIT;
        sum_next    = sum + tx_data;
        // The byte being accepted on the last payload transfer is included
        // here; the footer then carries the frozen checksum.
        footer_word = {seq_lat, 24'd0, sum_next};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ts       <= 64'd0;
            seq      <= 32'd0;
            seq_lat  <= 32'd0;
            word_sr  <= 64'd0;
            pay_sr   <= '0;
            cnt      <= '0;
            sum      <= 8'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ts      <= ts + 64'd1;
            // Any trigger seen while a frame is in flight (including the cycle
            // of its final transfer) is dropped and flagged.
            overrun <= trigger & enable & (state != IDLE);

            case (state)
                IDLE: begin
                    if (trigger & enable) begin
                        pay_sr   <= pulses;
                        word_sr  <= ts;
                        seq_lat  <= seq;
                        seq      <= seq + 32'd1;
                        sum      <= 8'd0;
                        cnt      <= '0;
                        // First header byte goes out in the next cycle.
                        tx_data  <= word_unit(ts);
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HEADER;
                    end
                end

                HEADER: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (cnt == HDR_LAST) begin
                            cnt     <= '0;
                            tx_data <= pay_unit(pay_sr);
                            state   <= PAYLOAD;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            word_sr <= word_next;
                            tx_data <= word_unit(word_next);
                        end
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (cnt == PAY_LAST) begin
                            cnt     <= '0;
                            word_sr <= footer_word;
                            tx_data <= word_unit(footer_word);
                            state   <= FOOTER;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            pay_sr  <= pay_next;
                            tx_data <= pay_unit(pay_next);
                        end
                    end
                end

                FOOTER: begin
                    // sum is not updated here: the footer is outside the checksum.
                    if (accept) begin
                        if (cnt == HDR_LAST) begin
                            cnt <= '0;
`ifdef PACKET_TERMINATOR_EN
                            tx_data <= 8'h0D;
                            state   <= TERM;
`else
                            tx_data  <= 8'd0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
`endif
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            word_sr <= word_next;
                            tx_data <= word_unit(word_next);
                        end
                    end
                end

`ifdef PACKET_TERMINATOR_EN
                TERM: begin
                    if (accept) begin
                        tx_data  <= 8'd0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif

                default: begin
                    tx_data  <= 8'd0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
